// File: rtl/mem_bus_pkg.sv
// Shared types and bus widths for the peripheral-bus arbiter.
package mem_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  // Returned to a master whose transfer was forced complete by the watchdog.
  localparam logic [DATA_W-1:0] DEFAULT_TIMEOUT_RDATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          any,
  output logic [PW-1:0] idx
);

  logic [N-1:0]  rot;
  logic [PW-1:0] first;

  // Rotate requests so position 0 is the master at ptr.
  always_comb begin
    rot = '0;
    for (int k = 0; k < N; k++) begin
      rot[k] = req[(int'(ptr) + k) % N];
    end
  end

  // Priority-encode the rotated vector (lowest wins), then undo the rotation.
  always_comb begin
    first = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) first = PW'(k);
    end
    any = |req;
    idx = PW'((int'(ptr) + int'(first)) % N);
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one valid/ready peripheral bus among several
// masters. A grant is held until the slave answers, followed by one release
// cycle so a registered slave ready can clear; a watchdog forces completion.
//
//  state   | meaning
//  IDLE    | no grant; pick next requester round-robin from rr_ptr
//  GRANT   | bus driven from granted master; wait for s_ready / timeout / abort
//  RELEASE | bus idle for one cycle; s_ready ignored
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int                NUM_MASTERS   = 2,
  parameter int                TIMEOUT       = 64,
  parameter logic [DATA_W-1:0] TIMEOUT_RDATA = DEFAULT_TIMEOUT_RDATA
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_MASTERS-1:0]        m_valid,
  input  logic [NUM_MASTERS-1:0]        m_instr,
  input  logic [STRB_W*NUM_MASTERS-1:0] m_wstrb,
  input  logic [DATA_W*NUM_MASTERS-1:0] m_wdata,
  input  logic [ADDR_W*NUM_MASTERS-1:0] m_addr,
  output logic [NUM_MASTERS-1:0]        m_ready,
  output logic [DATA_W*NUM_MASTERS-1:0] m_rdata,
  output logic                          s_valid,
  output logic                          s_instr,
  output logic [STRB_W-1:0]             s_wstrb,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [ADDR_W-1:0]             s_addr,
  input  logic                          s_ready,
  input  logic [DATA_W-1:0]             s_rdata,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int            PW = $clog2(NUM_MASTERS);
  localparam int            TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TC = TW'(TIMEOUT - 1);

  state_t        state;
  logic [PW-1:0] grant;
  logic [PW-1:0] rr_ptr;
  logic [TW-1:0] tcnt;
  logic [PW-1:0] next_ptr;
  logic          pick_any;
  logic [PW-1:0] pick_idx;
  logic          in_grant;
  logic          tc_hit;

  rr_pick #(.N(NUM_MASTERS), .PW(PW)) u_pick (
    .req (m_valid),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign next_ptr = (int'(grant) == NUM_MASTERS - 1) ? '0 : grant + PW'(1);
  assign in_grant = (state == GRANT);
  assign tc_hit   = (tcnt == TC);
  assign busy     = (state != IDLE);

  // Arbitration FSM with grant, round-robin pointer and watchdog counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      tcnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant <= pick_idx;
            tcnt  <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          // Completion, timeout and protocol abort all leave the same way.
          if (s_ready || tc_hit || !m_valid[grant]) begin
            rr_ptr <= next_ptr;
            state  <= RELEASE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Forward the granted master's request; bus fields are zero outside GRANT.
  always_comb begin
    s_valid = 1'b0;
    s_instr = 1'b0;
    s_wstrb = '0;
    s_wdata = '0;
    s_addr  = '0;
    if (in_grant) begin
      s_valid = 1'b1;
      s_instr = m_instr[grant];
      s_wstrb = m_wstrb[STRB_W*grant +: STRB_W];
      s_wdata = m_wdata[DATA_W*grant +: DATA_W];
      s_addr  = m_addr[ADDR_W*grant +: ADDR_W];
    end
  end

  // Return completion to the granted master only; a reset cycle never completes.
  always_comb begin
    m_ready     = '0;
    m_rdata     = '0;
    timeout_err = 1'b0;
    if (in_grant && resetn) begin
      if (s_ready) begin
        m_ready[grant]                   = 1'b1;
        m_rdata[DATA_W*grant +: DATA_W]  = s_rdata;
      end else if (tc_hit) begin
        m_ready[grant]                   = 1'b1;
        m_rdata[DATA_W*grant +: DATA_W]  = TIMEOUT_RDATA;
        timeout_err                      = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter with two masters and an 8-cycle watchdog.
module tb_mem_bus_arbiter;

  logic         clk = 1'b0;
  logic         resetn;
  logic [1:0]   m_valid;
  logic [1:0]   m_instr;
  logic [7:0]   m_wstrb;
  logic [63:0]  m_wdata;
  logic [63:0]  m_addr;
  logic [1:0]   m_ready;
  logic [63:0]  m_rdata;
  logic         s_valid;
  logic         s_instr;
  logic [3:0]   s_wstrb;
  logic [31:0]  s_wdata;
  logic [31:0]  s_addr;
  logic         s_ready;
  logic [31:0]  s_rdata;
  logic         busy;
  logic         timeout_err;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        to;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  mem_bus_arbiter #(.NUM_MASTERS(2), .TIMEOUT(8), .TIMEOUT_RDATA(32'hDEADBEEF)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .m_valid     (m_valid),
    .m_instr     (m_instr),
    .m_wstrb     (m_wstrb),
    .m_wdata     (m_wdata),
    .m_addr      (m_addr),
    .m_ready     (m_ready),
    .m_rdata     (m_rdata),
    .s_valid     (s_valid),
    .s_instr     (s_instr),
    .s_wstrb     (s_wstrb),
    .s_wdata     (s_wdata),
    .s_addr      (s_addr),
    .s_ready     (s_ready),
    .s_rdata     (s_rdata),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input logic v, input logic instr, input logic [3:0] strb,
                       input logic [31:0] wd, input logic [31:0] ad);
    m_valid[i]          = v;
    m_instr[i]          = instr;
    m_wstrb[4*i +: 4]   = strb;
    m_wdata[32*i +: 32] = wd;
    m_addr[32*i +: 32]  = ad;
  endtask

  // Slave side: wait for the grant, check forwarding, answer after delay cycles.
  // Returns in the RELEASE cycle, or in the following IDLE cycle when stale=1.
  task automatic serve(input int idx, input logic [31:0] addr, input logic [31:0] rd,
                       input int delay, input bit drop, input bit stale);
    int n;
    n = 0;
    while (s_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("grant_seen", 96'(s_valid), 96'(1));
    chk("fwd_addr", 96'(s_addr), 96'(addr));
    chk("fwd_wdata", 96'(s_wdata), 96'(m_wdata[32*idx +: 32]));
    chk("fwd_wstrb", 96'(s_wstrb), 96'(m_wstrb[4*idx +: 4]));
    chk("fwd_instr", 96'(s_instr), 96'(m_instr[idx]));
    repeat (delay) tick();
    s_ready = 1'b1;
    s_rdata = rd;
    exp_q.push_back('{idx, rd, 1'b0});
    tick();
    if (!stale) s_ready = 1'b0;
    if (drop) m_valid[idx] = 1'b0;
    chk("release_svalid", 96'(s_valid), 96'(0));
    chk("release_busy", 96'(busy), 96'(1));
    if (stale) begin
      tick();
      s_ready = 1'b0;
    end
    s_rdata = 32'h0;
  endtask

  // Monitor: pops the scoreboard on every completion, checks idle lanes otherwise.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (m_ready !== 2'b00) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_m_ready: got %b want 00 at %0t", m_ready, $time);
        end else begin
          e = exp_q.pop_front();
          chk("m_ready", 96'(m_ready), 96'(2'b01 << e.idx));
          chk("m_rdata_lane", 96'(m_rdata[32*e.idx +: 32]), 96'(e.rdata));
          chk("m_rdata_other", 96'(m_rdata[32*(1-e.idx) +: 32]), 96'(0));
          chk("timeout_err", 96'(timeout_err), 96'(e.to));
        end
      end else begin
        chk("idle_rdata", 96'(m_rdata), 96'(0));
        chk("idle_timeout_err", 96'(timeout_err), 96'(0));
      end
      if (s_valid !== 1'b1)
        chk("s_fields_zero", 96'({s_instr, s_wstrb, s_wdata, s_addr}), 96'(0));
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    resetn  = 1'b0;
    m_valid = '0;
    m_instr = '0;
    m_wstrb = '0;
    m_wdata = '0;
    m_addr  = '0;
    s_ready = 1'b0;
    s_rdata = '0;

    // Reset state
    tick();
    tick();
    chk("rst_busy", 96'(busy), 96'(0));
    chk("rst_svalid", 96'(s_valid), 96'(0));
    chk("rst_mready", 96'(m_ready), 96'(0));
    chk("rst_terr", 96'(timeout_err), 96'(0));
    resetn = 1'b1;
    tick();

    // 1: single master write, ready two cycles after grant
    set_m(0, 1'b1, 1'b0, 4'hF, 32'hA5A5_0F0F, 32'h2000_0000);
    tick();
    chk("t1_latency", 96'(s_valid), 96'(1));
    serve(0, 32'h2000_0000, 32'h0BAD_F00D, 2, 1'b1, 1'b0);
    tick();
    chk("t1_busy_drop", 96'(busy), 96'(0));

    // 2/3: contention from reset, then m1 read
    resetn = 1'b0;
    set_m(0, 1'b1, 1'b0, 4'h3, 32'h0000_1111, 32'h0000_0100);
    set_m(1, 1'b1, 1'b1, 4'h0, 32'h0000_2222, 32'h0000_0200);
    tick();
    tick();
    resetn = 1'b1;
    serve(0, 32'h0000_0100, 32'h0, 1, 1'b1, 1'b0);
    tick();
    chk("t2_gap_idle", 96'(s_valid), 96'(0));
    tick();
    chk("t2_gap_3cyc", 96'(s_valid), 96'(1));
    chk("t2_m1_addr", 96'(s_addr), 96'(32'h0000_0200));
    serve(1, 32'h0000_0200, 32'h1234_5678, 0, 1'b1, 1'b0);

    // 2: both held continuously -> 0,1,0,1
    m_valid = 2'b11;
    serve(0, 32'h0000_0100, 32'h1111_0000, 0, 1'b0, 1'b0);
    serve(1, 32'h0000_0200, 32'h2222_0000, 1, 1'b0, 1'b0);
    serve(0, 32'h0000_0100, 32'h3333_0000, 0, 1'b0, 1'b0);
    serve(1, 32'h0000_0200, 32'h4444_0000, 0, 1'b1, 1'b0);
    m_valid[0] = 1'b0;
    tick();
    tick();
    chk("t2_idle", 96'(busy), 96'(0));

    // 4: timeout on the 8th GRANT cycle
    set_m(0, 1'b1, 1'b1, 4'h0, 32'h0, 32'h3000_0000);
    n = 0;
    while (s_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("t4_grant", 96'(s_valid), 96'(1));
    chk("t4_instr", 96'(s_instr), 96'(1));
    repeat (7) tick();
    exp_q.push_back('{0, 32'hDEAD_BEEF, 1'b1});
    chk("t4_terr_8th", 96'(timeout_err), 96'(1));
    chk("t4_mready_8th", 96'(m_ready), 96'(2'b01));
    tick();
    m_valid[0] = 1'b0;
    chk("t4_release", 96'(s_valid), 96'(0));
    chk("t4_release_busy", 96'(busy), 96'(1));
    tick();
    chk("t4_idle", 96'(busy), 96'(0));

    // Abort: m1 drops valid mid-grant, no completion
    set_m(1, 1'b1, 1'b0, 4'hF, 32'h5555_AAAA, 32'h4000_0000);
    tick();
    chk("abort_grant", 96'(s_valid), 96'(1));
    tick();
    m_valid[1] = 1'b0;
    tick();
    chk("abort_release", 96'(s_valid), 96'(0));
    tick();
    chk("abort_idle", 96'(busy), 96'(0));

    // 5: stale slave ready held into RELEASE, next master unaffected
    set_m(0, 1'b1, 1'b0, 4'hF, 32'h0101_0101, 32'h5000_0000);
    set_m(1, 1'b1, 1'b0, 4'h1, 32'h0202_0202, 32'h5000_0004);
    serve(0, 32'h5000_0000, 32'h0, 0, 1'b1, 1'b1);
    serve(1, 32'h5000_0004, 32'hCAFE_0001, 1, 1'b1, 1'b0);
    tick();
    tick();

    // 6: reset mid-GRANT with rr_ptr=1 beforehand
    set_m(0, 1'b1, 1'b0, 4'hF, 32'h0606_0000, 32'h6000_0000);
    serve(0, 32'h6000_0000, 32'h0, 0, 1'b1, 1'b0);
    tick();
    set_m(0, 1'b1, 1'b0, 4'hF, 32'h0606_0000, 32'h6000_0000);
    set_m(1, 1'b1, 1'b0, 4'hF, 32'h0707_0000, 32'h6000_0010);
    tick();
    chk("t6_m1_granted", 96'(s_addr), 96'(32'h6000_0010));
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("t6_svalid", 96'(s_valid), 96'(0));
    chk("t6_busy", 96'(busy), 96'(0));
    serve(0, 32'h6000_0000, 32'h0000_0006, 0, 1'b1, 1'b0);
    serve(1, 32'h6000_0010, 32'h0000_0007, 0, 1'b1, 1'b0);
    repeat (3) tick();

    chk("scoreboard_empty", 96'(exp_q.size()), 96'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
